uart_axil_regif: RTL and testbench

- AXI4-Lite slave register front-end for the chipset UART, sitting directly downstream of the tile-side UART AXI4-Lite master port (13-bit address, 32-bit data).
- Converts register reads and writes into byte streams to and from the UART serializer/deserializer, buffering both directions in FIFOs.
- Generates the level UART interrupt that is routed back to the cores.

---
 rtl/uart_axil_regif.sv | 193 +++++++++++++++++++
 tb/tb_uart_axil_regif.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_axil_regif.sv
// AXI4-Lite register front-end for the chipset UART: TX/RX byte FIFOs,
// sticky overrun flags, IRQ enables and a registered level interrupt.
// Ports: chipset_clk/chipset_rst_n; s_axi_* AXI4-Lite slave (AW/W/B/AR/R);
// tx_data/tx_valid/tx_ready to the serializer; rx_data/rx_valid from the
// deserializer; irq level interrupt to the cores.
module uart_axil_regif #(
  parameter int ADDR_W     = 13,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              chipset_clk,
  input  logic              chipset_rst_n,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PONE = 1;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic          wr_hs, rd_hs, w_map, r_map;
  logic [1:0]    w_off, r_off;
  logic          wr_tx, wr_st, wr_ct;
  logic          tx_flush, rx_flush;
  logic [PW:0]   tx_wp, tx_rp, rx_wp, rx_rp;
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic          tx_pop, tx_push, rx_pop, rx_push;
  logic          tx_ovr_set, rx_ovr_set;
  logic          rxovr, txovr, rx_irq_en, tx_irq_en;
  logic [31:0]   rd_word;
  logic [1:0]    rd_resp;

  // AW and W must arrive together; a pending B response stalls both.
  assign wr_hs = s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid;
  assign s_axi_awready = wr_hs;
  assign s_axi_wready  = wr_hs;
  assign s_axi_arready = ~s_axi_rvalid;
  assign rd_hs = s_axi_arvalid & ~s_axi_rvalid;

  assign w_map = (s_axi_awaddr[ADDR_W-1:4] == '0);
  assign r_map = (s_axi_araddr[ADDR_W-1:4] == '0);
  assign w_off = s_axi_awaddr[3:2];
  assign r_off = s_axi_araddr[3:2];

  assign wr_tx = wr_hs & w_map & (w_off == 2'd1);
  assign wr_st = wr_hs & w_map & (w_off == 2'd2);
  assign wr_ct = wr_hs & w_map & (w_off == 2'd3);
  assign tx_flush = wr_ct & s_axi_wdata[2];
  assign rx_flush = wr_ct & s_axi_wdata[3];

  // Extra pointer MSB distinguishes full from empty.
  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[PW] != tx_rp[PW]) &&
                    (tx_wp[PW-1:0] == tx_rp[PW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[PW] != rx_rp[PW]) &&
                    (rx_wp[PW-1:0] == rx_rp[PW-1:0]);

  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_mem[tx_rp[PW-1:0]];

  assign tx_pop  = tx_valid & tx_ready;
  assign tx_push = wr_tx & (~tx_full | tx_pop);
  assign tx_ovr_set = wr_tx & tx_full & ~tx_pop;

  assign rx_pop  = rd_hs & r_map & (r_off == 2'd0) & ~rx_empty;
  assign rx_push = rx_valid & (~rx_full | rx_pop);
  assign rx_ovr_set = rx_valid & rx_full & ~rx_pop;

  always_ff @(posedge chipset_clk) begin
    if (tx_push)
      tx_mem[tx_wp[PW-1:0]] <= s_axi_wdata[7:0];
    if (rx_push)
      rx_mem[rx_wp[PW-1:0]] <= rx_data;
  end

  // Flush collapses read pointer onto write pointer and drops
  // any same-cycle push or pop.
  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (tx_flush) begin
        tx_rp <= tx_wp;
      end else begin
        if (tx_push) tx_wp <= tx_wp + PONE;
        if (tx_pop)  tx_rp <= tx_rp + PONE;
      end
      if (rx_flush) begin
        rx_rp <= rx_wp;
      end else begin
        if (rx_push) rx_wp <= rx_wp + PONE;
        if (rx_pop)  rx_rp <= rx_rp + PONE;
      end
    end
  end

  // Sticky flags: a same-cycle set beats the W1C.
  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) begin
      rxovr     <= 1'b0;
      txovr     <= 1'b0;
      rx_irq_en <= 1'b0;
      tx_irq_en <= 1'b0;
    end else begin
      if (rx_ovr_set)
        rxovr <= 1'b1;
      else if (wr_st & s_axi_wdata[4])
        rxovr <= 1'b0;
      if (tx_ovr_set)
        txovr <= 1'b1;
      else if (wr_st & s_axi_wdata[5])
        txovr <= 1'b0;
      if (wr_ct) begin
        rx_irq_en <= s_axi_wdata[0];
        tx_irq_en <= s_axi_wdata[1];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    rd_resp = OKAY;
    if (!r_map) begin
      rd_resp = SLVERR;
    end else begin
      unique case (r_off)
        2'd0: rd_word = {rx_empty, 23'b0, rx_mem[rx_rp[PW-1:0]]};
        2'd1: rd_word = '0;
        2'd2: rd_word = {26'b0, txovr, rxovr, tx_full,
                         tx_empty, rx_full, ~rx_empty};
        2'd3: rd_word = {30'b0, tx_irq_en, rx_irq_en};
        default: rd_word = '0;
      endcase
    end
    // An empty RX FIFO reads as just the empty flag.
    if (r_map && r_off == 2'd0 && rx_empty)
      rd_word = 32'h8000_0000;
  end

  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) begin
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= OKAY;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= OKAY;
      irq          <= 1'b0;
    end else begin
      if (wr_hs) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= w_map ? OKAY : SLVERR;
      end else if (s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
      if (rd_hs) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_word;
        s_axi_rresp  <= rd_resp;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
      irq <= (rx_irq_en & ~rx_empty) |
             (tx_irq_en & tx_empty) | rxovr;
    end
  end

endmodule

// File: tb/tb_uart_axil_regif.sv
// Directed testbench for uart_axil_regif.
// Drives inputs on the falling edge and samples there as well.
module tb_uart_axil_regif;

  logic        clk;
  logic        rst_n;
  logic [12:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [12:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        irq;

  int pass_cnt = 0;
  int total_cnt = 0;

  uart_axil_regif #(.ADDR_W(13), .FIFO_DEPTH(16)) dut (
    .chipset_clk   (clk),
    .chipset_rst_n (rst_n),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic axi_write(input logic [12:0] a, input logic [31:0] d,
                           output logic [1:0] resp);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin
      @(negedge clk); n++;
    end
    total_cnt++;
    if (!bvalid)
      $display("FAIL wr_timeout addr=%h: bvalid=%b required 1", a, bvalid);
    else
      pass_cnt++;
    resp = bresp;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [12:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output logic lat1);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    arvalid = 1'b0;
    lat1 = rvalid;
    n = 0;
    while (!rvalid && n < 20) begin
      @(negedge clk); n++;
    end
    total_cnt++;
    if (!rvalid)
      $display("FAIL rd_timeout addr=%h: rvalid=%b required 1", a, rvalid);
    else
      pass_cnt++;
    d = rdata; resp = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic push_rx(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d; logic [1:0] r; logic l;
    total_cnt++;
    if ({irq, arready, tx_valid, bvalid, rvalid} !== 5'b01000)
      $display("FAIL reset_outs: got %b required 01000",
               {irq, arready, tx_valid, bvalid, rvalid});
    else pass_cnt++;
    axi_read(13'h8, d, r, l);
    total_cnt++;
    if (d !== 32'h4) $display("FAIL reset_status: got %h required 4", d);
    else pass_cnt++;
    total_cnt++;
    if (r !== 2'b00) $display("FAIL reset_rresp: got %b required 00", r);
    else pass_cnt++;
    total_cnt++;
    if (l !== 1'b1) $display("FAIL rd_latency: rvalid=%b required 1", l);
    else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL reset_irq: got %b required 0", irq);
    else pass_cnt++;
  endtask

  task automatic test_tx;
    logic [31:0] d; logic [1:0] r; logic l;
    tx_ready = 1'b0;
    axi_write(13'h4, 32'h41, r);
    axi_write(13'h4, 32'h42, r);
    total_cnt++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h41})
      $display("FAIL tx_head: got %b/%h required 1/41", tx_valid, tx_data);
    else pass_cnt++;
    @(negedge clk);
    tx_ready = 1'b1;
    total_cnt++;
    if (tx_data !== 8'h41)
      $display("FAIL tx_out0: got %h required 41", tx_data);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h42})
      $display("FAIL tx_out1: got %b/%h required 1/42", tx_valid, tx_data);
    else pass_cnt++;
    @(negedge clk);
    tx_ready = 1'b0;
    total_cnt++;
    if (tx_valid !== 1'b0)
      $display("FAIL tx_drained: got %b required 0", tx_valid);
    else pass_cnt++;
    axi_read(13'h8, d, r, l);
    total_cnt++;
    if (d !== 32'h4) $display("FAIL tx_status: got %h required 4", d);
    else pass_cnt++;
  endtask

  task automatic test_rx_overflow;
    logic [31:0] d; logic [1:0] r; logic l;
    for (int i = 0; i < 16; i++) push_rx(8'(i));
    push_rx(8'hFF);
    axi_read(13'h8, d, r, l);
    total_cnt++;
    if (d !== 32'h17) $display("FAIL rxovr_status: got %h required 17", d);
    else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL rxovr_irq: got %b required 1", irq);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      axi_read(13'h0, d, r, l);
      total_cnt++;
      if (d !== 32'(i))
        $display("FAIL rx_pop%0d: got %h required %h", i, d, 32'(i));
      else pass_cnt++;
    end
    axi_read(13'h0, d, r, l);
    total_cnt++;
    if (d !== 32'h8000_0000)
      $display("FAIL rx_empty_rd: got %h required 80000000", d);
    else pass_cnt++;
    axi_write(13'h8, 32'h10, r);
    axi_read(13'h8, d, r, l);
    total_cnt++;
    if (d !== 32'h4) $display("FAIL rxovr_w1c: got %h required 4", d);
    else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_clr: got %b required 0", irq);
    else pass_cnt++;
  endtask

  task automatic test_full_pop_push;
    logic [31:0] d; logic [1:0] r; logic l;
    for (int i = 0; i < 16; i++) push_rx(8'(8'h10 + i));
    @(negedge clk);
    araddr = 13'h0; arvalid = 1'b1;
    rx_data = 8'hAA; rx_valid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; rx_valid = 1'b0;
    total_cnt++;
    if ({rvalid, rdata} !== {1'b1, 32'h10})
      $display("FAIL coinc_rd: got %b/%h required 1/10", rvalid, rdata);
    else pass_cnt++;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    axi_read(13'h8, d, r, l);
    total_cnt++;
    if (d !== 32'h7) $display("FAIL coinc_status: got %h required 7", d);
    else pass_cnt++;
    for (int i = 1; i < 16; i++) begin
      axi_read(13'h0, d, r, l);
      total_cnt++;
      if (d !== 32'(8'h10 + i))
        $display("FAIL coinc_pop%0d: got %h required %h",
                 i, d, 32'(8'h10 + i));
      else pass_cnt++;
    end
    axi_read(13'h0, d, r, l);
    total_cnt++;
    if (d !== 32'hAA) $display("FAIL coinc_last: got %h required aa", d);
    else pass_cnt++;
  endtask

  task automatic test_unmapped;
    logic [31:0] d; logic [1:0] r; logic l;
    logic held;
    push_rx(8'h5A);
    axi_read(13'h10, d, r, l);
    total_cnt++;
    if ({r, d} !== {2'b10, 32'h0})
      $display("FAIL unm_rd: got %b/%h required 10/0", r, d);
    else pass_cnt++;
    axi_write(13'h14, 32'h77, r);
    total_cnt++;
    if (r !== 2'b10) $display("FAIL unm_wr: got %b required 10", r);
    else pass_cnt++;
    axi_write(13'h1C, 32'h2, r);
    axi_read(13'h8, d, r, l);
    total_cnt++;
    if (d !== 32'h5) $display("FAIL unm_noside: got %h required 5", d);
    else pass_cnt++;
    axi_read(13'hC, d, r, l);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL unm_ctrl: got %h required 0", d);
    else pass_cnt++;
    axi_read(13'h0, d, r, l);
    total_cnt++;
    if (d !== 32'h5A) $display("FAIL unm_rxbyte: got %h required 5a", d);
    else pass_cnt++;
    @(negedge clk);
    awaddr = 13'h10; wdata = 32'h3; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(bvalid && !awready && bresp == 2'b10)) held = 1'b0;
      @(negedge clk);
    end
    total_cnt++;
    if (held !== 1'b1)
      $display("FAIL b_hold: got %b required 1", held);
    else pass_cnt++;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    total_cnt++;
    if (bvalid !== 1'b0) $display("FAIL b_release: got %b required 0", bvalid);
    else pass_cnt++;
  endtask

  task automatic test_ctrl;
    logic [31:0] d; logic [1:0] r; logic l;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) axi_write(13'h4, 32'(i), r);
    axi_write(13'hC, 32'h4, r);
    total_cnt++;
    if (tx_valid !== 1'b0) $display("FAIL tx_flush: got %b required 0", tx_valid);
    else pass_cnt++;
    axi_write(13'hC, 32'h7, r);
    axi_read(13'hC, d, r, l);
    total_cnt++;
    if (d !== 32'h3) $display("FAIL ctrl_rd: got %h required 3", d);
    else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL tx_irq: got %b required 1", irq);
    else pass_cnt++;
    axi_write(13'hC, 32'h0, r);
    @(negedge clk);
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_off: got %b required 0", irq);
    else pass_cnt++;
  endtask

  task automatic test_reset_midflight;
    logic [31:0] d; logic [1:0] r; logic l;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) axi_write(13'h4, 32'(8'h30 + i), r);
    @(negedge clk);
    araddr = 13'h8; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({rvalid, tx_valid} !== 2'b00)
      $display("FAIL async_rst: got %b required 00", {rvalid, tx_valid});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    axi_read(13'h8, d, r, l);
    total_cnt++;
    if (d !== 32'h4) $display("FAIL post_rst: got %h required 4", d);
    else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_tx();
    test_rx_overflow();
    test_full_pop_push();
    test_unmapped();
    test_ctrl();
    test_reset_midflight();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
